// File: rtl/mem_backend_pkg.sv
// Shared types and default sizing for the main-memory backend.
package mem_backend_pkg;

    localparam int unsigned MEM_LATENCY_DEF    = 4;
    localparam int unsigned MEM_LINE_WORDS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_WAIT  = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_backend_if.sv
// Request/refill bus between the cache controller (master) and the memory backend (slave).
interface mem_backend_if #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              busy;
    logic              done;
    logic              refill_valid;
    logic [IDX_W-1:0]  refill_idx;
    logic [DATA_W-1:0] refill_data;

    modport master (
        output mem_read, mem_write, address, wdata, wstrb,
        input  busy, done, refill_valid, refill_idx, refill_data
    );

    modport slave (
        input  mem_read, mem_write, address, wdata, wstrb,
        output busy, done, refill_valid, refill_idx, refill_data
    );

endinterface

// File: rtl/mem_backend_array.sv
// Word storage: synchronous byte-strobed write, combinational read. Contents are not reset.
module mem_backend_array #(
    parameter int unsigned WADDR_W = 8,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [WADDR_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [WADDR_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);
    localparam int unsigned DEPTH  = 1 << WADDR_W;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_backend.sv
// Fixed-latency main-memory backend: line refill bursts and byte-strobed write-through.
// Optional macro CRITICAL_WORD_FIRST_EN starts the refill burst at the requested word.
module mem_backend
    import mem_backend_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = MEM_LINE_WORDS_DEF,
    parameter int unsigned LATENCY    = MEM_LATENCY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_backend_if.slave  bus
);
    localparam int unsigned IDX_W   = $clog2(LINE_WORDS);
    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned CNT_W   = $clog2(LATENCY + 1);
    localparam int unsigned STRB_W  = DATA_W / 8;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     idx_nxt_c;
    logic [IDX_W-1:0]     start_c;
    logic [WADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic                 we_c;
    logic [WADDR_W-1:0]   raddr_c;
    logic [DATA_W-1:0]    rdata_c;

    logic                 busy_q;
    logic                 done_q;
    logic                 refill_valid_q;
    logic [IDX_W-1:0]     refill_idx_q;
    logic [DATA_W-1:0]    refill_data_q;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_c = waddr_q[IDX_W-1:0];
`else
    assign start_c = '0;
`endif

    // Index wraps naturally because LINE_WORDS is a power of two.
    assign idx_nxt_c = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    state_d = bus.mem_read ? RD_WAIT : WR_WAIT;
                    cnt_d   = '0;
                    waddr_d = bus.address[ADDR_W-1:2];
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                end
            end
            RD_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = RD_BURST;
                    cnt_d   = '0;
                    idx_d   = start_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_BURST: begin
                idx_d = idx_nxt_c;
                if (idx_nxt_c == start_c) begin
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    we_c    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read port addresses the word that will be presented next cycle.
    assign raddr_c = {waddr_q[WADDR_W-1:IDX_W], idx_d};

    mem_backend_array #(
        .WADDR_W (WADDR_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (waddr_q),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .raddr_i (raddr_c),
        .rdata_o (rdata_c)
    );

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            refill_valid_q <= 1'b0;
            refill_idx_q   <= '0;
            refill_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            busy_q         <= (state_d != IDLE);
            done_q         <= (state_d == DONE);
            refill_valid_q <= (state_d == RD_BURST);
            refill_idx_q   <= (state_d == RD_BURST) ? idx_d : '0;
            refill_data_q  <= (state_d == RD_BURST) ? rdata_c : '0;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.refill_valid = refill_valid_q;
    assign bus.refill_idx   = refill_idx_q;
    assign bus.refill_data  = refill_data_q;

endmodule

// File: doc/mem_backend.md
Name: mem_backend

Overview:
Main-memory backend that sits directly downstream of the cache controller. It accepts two kinds of request:
- line refill: held mem_read
- write-through: held mem_write

It models a fixed-latency memory. For a refill it streams the whole line back one word per cycle. It signals completion with a one-cycle done pulse, which the cache controller uses to release the stall.

Parameters:
ADDR_W, 10, byte-address width; storage holds 2**ADDR_W/4 words.
DATA_W, 32, word width; must be 32.
LINE_WORDS, 4, words per cache line; power of two, at least 2.
LATENCY, 4, access wait cycles before data or commit; at least 1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
mem_read  in  1  refill request, held until done
mem_write  in  1  write-through request, held until done
address  in  ADDR_W  byte address of the request
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables for the write
busy  out  1  high whenever not IDLE
done  out  1  one-cycle completion pulse
refill_valid  out  1  refill word present this cycle
refill_idx  out  $clog2(LINE_WORDS)  word index within the line
refill_data  out  DATA_W  refill word

Behaviour:
- Reset:
  - rst low forces state IDLE, counter 0, burst index 0.
  - All outputs go to 0: busy, done, refill_valid, refill_idx, refill_data.
  - Storage contents are not reset.
- States: IDLE, RD_WAIT, RD_BURST, WR_WAIT, DONE.
- IDLE:
  - mem_read high at an edge: accept, go to RD_WAIT.
  - Else mem_write high: accept, go to WR_WAIT.
  - Read has priority when both are high; the write stays pending and is accepted in a later IDLE.
- Capture at accept: address, wdata and wstrb are registered. Later input changes are ignored until the request completes.
- Line base = address with the low $clog2(LINE_WORDS)+2 bits cleared. Address bits [1:0] are ignored for writes.
- RD_WAIT: stays exactly LATENCY cycles (counter counts up from 0), then goes to RD_BURST.
- RD_BURST:
  - Lasts LINE_WORDS cycles.
  - Each cycle: refill_valid=1, refill_idx=k, refill_data=mem[line base word + k].
  - k runs 0..LINE_WORDS-1 (see Optional Feature).
  - After the last word, go to DONE.
- WR_WAIT:
  - Stays LATENCY cycles.
  - On the edge leaving WR_WAIT, bytes with wstrb set are written into the target word; other bytes keep their value.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Cycle numbering: accept edge is cycle 0.
  - Read: burst in cycles LATENCY+1..LATENCY+LINE_WORDS; done in cycle LATENCY+LINE_WORDS+1.
  - Write: done in cycle LATENCY+1.
- Requester contract: deassert the request in the cycle after done. A request still high in the following IDLE is a new request.
- refill_valid and refill_data are 0 outside RD_BURST.
- Reset mid-operation: the request is aborted. A write not yet past its commit edge is never committed.
- The counter width must hold LATENCY without wrap.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: the burst starts at the requested word, address[$clog2(LINE_WORDS)+1:2]. It wraps modulo LINE_WORDS; refill_idx reports the true index of each word. Total burst length and done timing are unchanged.
- Undefined: the burst is always in order 0..LINE_WORDS-1.

Decomposition:
- Package mem_backend_pkg holds:
  - the state_t enum, logic [2:0]
  - default constants MEM_LATENCY_DEF=4 and MEM_LINE_WORDS_DEF=4
- One sub-module, mem_backend_array: word storage with synchronous byte-strobed write and combinational read port. The FSM, counter and burst index stay in mem_backend.

Test Plan:
Defaults LATENCY=4, LINE_WORDS=4; preload mem word w = 0x1000_0000 + w.
1. rst low while mem_read=1 for 5 cycles -> busy=0, done=0, refill_valid=0 throughout. After release, read accepted at the first edge.
2. mem_read at address 0x084:
   - refill_valid in cycles 5-8
   - idx 0,1,2,3 with data 0x10000020..0x10000023
   - done=1 only in cycle 9; busy low in cycle 10.
3. Word at 0x0C8 holds 0x11223344; mem_write at 0x0C8, wdata 0xDEADBEEF, wstrb 4'b0011 -> done in cycle 5, no refill_valid. Word becomes 0x1122BEEF; a later refill of line 0x0C0 returns it at idx 2.
4. mem_read and mem_write both high in IDLE:
   - Read serviced first (done cycle 9).
   - Read then dropped while write held: write accepted in the next IDLE, with done LATENCY+1 cycles after that accept.
5. Write accepted, rst pulsed low in cycle 3 -> outputs 0 and state IDLE immediately; the target word is unchanged.
6. With CRITICAL_WORD_FIRST_EN, read at 0x08C -> idx order 3,0,1,2 with matching data; done still in cycle 9.
